instr_mem_fetch: RTL and testbench

Parametrised, loadable instruction memory with a registered fetch port for the pipelined datapath. It replaces the fixed, combinational, hard-coded ROM. A program-load port writes words at run time. The fetch port has 1-cycle latency, a valid/ready handshake with backpressure, and fault reporting for misaligned, out-of-range and never-written addresses.

---
 rtl/instr_mem_fetch.sv | 173 +++++++++++++++++
 tb/tb_instr_mem_fetch.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_fetch.sv
// Loadable instruction memory with a registered, handshaked fetch port.
// A load port writes words while the block is in LOAD mode, and a fetch port
// returns one word per accepted request with exactly one cycle of latency.
// Misaligned, out-of-range and never-written fetches return FAULT_WORD
// together with a fault code.
module instr_mem_fetch #(
    parameter int                DATA_W     = 32,
    parameter int                DEPTH      = 32,
    parameter int                ADDR_W     = 32,
    parameter logic [DATA_W-1:0] FAULT_WORD = DATA_W'(32'hFC00_0000)
) (
    input  logic                         clk,
    input  logic                         reset_n,
    // program-load port
    input  logic                         load_en,
    input  logic                         load_valid,
    input  logic [ADDR_W-1:0]            load_addr,
    input  logic [DATA_W-1:0]            load_data,
    output logic                         load_ready,
    output logic                         load_err,
    output logic [$clog2(DEPTH+1)-1:0]   loaded_cnt,
    // fetch port
    input  logic                         req_valid,
    input  logic [ADDR_W-1:0]            req_addr,
    output logic                         req_ready,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [DATA_W-1:0]            rsp_data,
    output logic [1:0]                   rsp_fault
);

    localparam int OFS   = $clog2(DATA_W / 8);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    // Byte-offset bits inside one word; zero mask when words are one byte.
    localparam logic [ADDR_W-1:0] OFS_MASK = ADDR_W'((1 << OFS) - 1);
    localparam logic [ADDR_W-1:0] DEPTH_A  = ADDR_W'(DEPTH);

    localparam logic [1:0] F_OK    = 2'd0;
    localparam logic [1:0] F_MISAL = 2'd1;
    localparam logic [1:0] F_RANGE = 2'd2;
    localparam logic [1:0] F_UNWR  = 2'd3;

    typedef enum logic [1:0] {RUN, DRAIN, LOAD} state_t;

    state_t state, state_next;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  written;

    // Address decode: the full word index is compared against DEPTH, so
    // high address bits never alias onto a valid word.
    logic [ADDR_W-1:0] req_word, load_word;
    logic [IDX_W-1:0]  req_idx, load_idx;
    logic              load_legal;
    logic [1:0]        fetch_fault;
    logic              req_fire, load_fire, rsp_take;

    assign req_word   = req_addr >> OFS;
    assign load_word  = load_addr >> OFS;
    assign req_idx    = req_word[IDX_W-1:0];
    assign load_idx   = load_word[IDX_W-1:0];
    assign load_legal = ((load_addr & OFS_MASK) == '0) && (load_word < DEPTH_A);

    assign req_fire  = req_valid && req_ready;
    assign load_fire = load_valid && load_ready;
    assign rsp_take  = rsp_valid && rsp_ready;

    // Fault classification with priority misaligned > out of range > unwritten.
    always_comb begin
        // NOTE: every signal assigned in a combinational block gets a default
        // first, so no path leaves it unassigned and no latch is inferred.
        fetch_fault = F_OK;
        if ((req_addr & OFS_MASK) != '0) begin
            fetch_fault = F_MISAL;
        end else if (req_word >= DEPTH_A) begin
            fetch_fault = F_RANGE;
        end else if (!written[req_idx]) begin
            fetch_fault = F_UNWR;
        end
    end

    // Mode register.
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: clocked state uses non-blocking assignments so every register
        // samples pre-edge values regardless of block evaluation order.
        if (!reset_n) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // Next mode and the two ready signals derived from it.
    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        load_ready = 1'b0;
        unique case (state)
            RUN: begin
                req_ready = !rsp_valid || rsp_ready;
                if (load_en) begin
                    // An in-flight response must be consumed before loading.
                    state_next = (!rsp_valid || rsp_ready) ? LOAD : DRAIN;
                end
            end
            DRAIN: begin
                if (!load_en) begin
                    state_next = RUN;
                end else if (rsp_take) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                load_ready = 1'b1;
                if (!load_en) begin
                    state_next = RUN;
                end
            end
            default: state_next = RUN;
        endcase
    end

    // Response register: loads on accept, drops valid once consumed, and
    // otherwise holds data and fault code unchanged.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_fault <= F_OK;
        end else if (req_fire) begin
            rsp_valid <= 1'b1;
            rsp_data  <= (fetch_fault == F_OK) ? mem[req_idx] : FAULT_WORD;
            rsp_fault <= fetch_fault;
        end else if (rsp_take) begin
            rsp_valid <= 1'b0;
        end
    end

    // Load bookkeeping: written bits, distinct-word count and sticky error.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            written    <= '0;
            loaded_cnt <= '0;
            load_err   <= 1'b0;
        end else begin
            if (state != LOAD && state_next == LOAD) begin
                load_err <= 1'b0;
            end
            if (load_fire) begin
                if (load_legal) begin
                    written[load_idx] <= 1'b1;
                    if (!written[load_idx]) begin
                        loaded_cnt <= loaded_cnt + CNT_W'(1);
                    end
                end else begin
                    load_err <= 1'b1;
                end
            end
        end
    end

    // Instruction storage write port.
    always_ff @(posedge clk) begin
        // NOTE: the array has no reset; the written bits alone say which
        // words hold valid data, so the storage can map onto plain RAM.
        if (load_fire && load_legal) begin
            mem[load_idx] <= load_data;
        end
    end

endmodule

// File: tb/tb_instr_mem_fetch.sv
// Self-checking bench for instr_mem_fetch: directed steps followed by a
// randomized phase, all compared against a behavioural model of the memory.
module tb_instr_mem_fetch;

    localparam int          DEPTH = 32;
    localparam logic [31:0] FW    = 32'hFC00_0000;

    // Model modes: what the block should be doing, not how it encodes it.
    localparam int M_RUN   = 0;
    localparam int M_DRAIN = 1;
    localparam int M_LOAD  = 2;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        load_en = 1'b0, load_valid = 1'b0;
    logic [31:0] load_addr = '0, load_data = '0;
    logic        load_ready, load_err;
    logic [5:0]  loaded_cnt;
    logic        req_valid = 1'b0;
    logic [31:0] req_addr = '0;
    logic        req_ready, rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_data;
    logic [1:0]  rsp_fault;

    int checks = 0;
    int errors = 0;

    // Behavioural model state.
    logic [31:0] m_mem [DEPTH];
    bit          m_wr  [DEPTH];
    int          m_cnt;
    bit          m_err;
    int          m_mode;
    bit          m_rv;
    logic [31:0] m_rd;
    logic [1:0]  m_rf;

    instr_mem_fetch dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .load_en    (load_en),
        .load_valid (load_valid),
        .load_addr  (load_addr),
        .load_data  (load_data),
        .load_ready (load_ready),
        .load_err   (load_err),
        .loaded_cnt (loaded_cnt),
        .req_valid  (req_valid),
        .req_addr   (req_addr),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_fault  (rsp_fault)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] exp_fault(input logic [31:0] a);
        if (a % 4 != 0)          return 2'd1;
        if (a / 4 >= DEPTH)      return 2'd2;
        if (!m_wr[a / 4])        return 2'd3;
        return 2'd0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m_wr[i] = 1'b0;
        m_cnt  = 0;
        m_err  = 1'b0;
        m_mode = M_RUN;
        m_rv   = 1'b0;
        m_rd   = '0;
        m_rf   = 2'd0;
    endtask

    task automatic check_regs(input string tag);
        check({tag, ".rsp_valid"}, 64'(rsp_valid), 64'(m_rv));
        check({tag, ".rsp_data"}, 64'(rsp_data), 64'(m_rd));
        check({tag, ".rsp_fault"}, 64'(rsp_fault), 64'(m_rf));
        check({tag, ".load_err"}, 64'(load_err), 64'(m_err));
        check({tag, ".loaded_cnt"}, 64'(loaded_cnt), 64'(m_cnt));
    endtask

    // One clock cycle: drive at the falling edge, check ready outputs
    // shortly after, advance the model, then check registers at the next
    // falling edge.
    task automatic step(input string tag, input logic le, input logic lv,
                        input logic [31:0] la, input logic [31:0] ld,
                        input logic rv, input logic [31:0] ra, input logic rr);
        bit          exp_req_ready, exp_load_ready, acc, took;
        logic [1:0]  f;
        load_en = le; load_valid = lv; load_addr = la; load_data = ld;
        req_valid = rv; req_addr = ra; rsp_ready = rr;
        #1;
        exp_req_ready  = (m_mode == M_RUN) && (!m_rv || rr);
        exp_load_ready = (m_mode == M_LOAD);
        check({tag, ".req_ready"}, 64'(req_ready), 64'(exp_req_ready));
        check({tag, ".load_ready"}, 64'(load_ready), 64'(exp_load_ready));

        acc  = rv && exp_req_ready;
        took = m_rv && rr;
        if (acc) begin
            f    = exp_fault(ra);
            m_rv = 1'b1;
            m_rf = f;
            m_rd = (f == 2'd0) ? m_mem[ra / 4] : FW;
        end else if (took) begin
            m_rv = 1'b0;
        end
        if (lv && exp_load_ready) begin
            if (la % 4 == 0 && la / 4 < DEPTH) begin
                if (!m_wr[la / 4]) m_cnt++;
                m_wr[la / 4]  = 1'b1;
                m_mem[la / 4] = ld;
            end else begin
                m_err = 1'b1;
            end
        end
        case (m_mode)
            M_RUN:   if (le) begin
                         m_mode = (!m_rv || rr || took) ? M_LOAD : M_DRAIN;
                         if (m_mode == M_LOAD) m_err = 1'b0;
                     end
            M_DRAIN: if (!le) m_mode = M_RUN;
                     else if (took) begin m_mode = M_LOAD; m_err = 1'b0; end
            default: if (!le) m_mode = M_RUN;
        endcase
        @(negedge clk);
        check_regs(tag);
    endtask

    task automatic fetch(input string tag, input logic [31:0] a);
        step(tag, 1'b0, 1'b0, '0, '0, 1'b1, a, 1'b1);
    endtask

    task automatic load(input string tag, input logic [31:0] a, input logic [31:0] d);
        step(tag, 1'b1, 1'b1, a, d, 1'b0, '0, 1'b1);
    endtask

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 9))
            0:       return ($urandom_range(0, DEPTH - 1) * 4) + $urandom_range(1, 3);
            1:       return 32'(DEPTH * 4) + ($urandom_range(0, 63) * 4);
            2:       return 32'hFFFF_FFFC - ($urandom_range(0, 7) * 4);
            default: return $urandom_range(0, DEPTH - 1) * 4;
        endcase
    endfunction

    initial begin
        logic le_r;
        model_reset();

        // Reset and initial state.
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check_regs("reset");
        check("reset.req_ready", 64'(req_ready), 64'(1));
        check("reset.load_ready", 64'(load_ready), 64'(0));

        // Fetch from an empty memory.
        fetch("empty_fetch", 32'h0);

        // Load a short program, then fetch it back-to-back.
        step("enter_load", 1'b1, 1'b0, '0, '0, 1'b0, '0, 1'b1);
        load("load0", 32'h0, 32'h8C01_0008);
        load("load4", 32'h4, 32'hAC01_0010);
        load("load8", 32'h8, 32'h8C20_0001);
        step("exit_load", 1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b1);
        fetch("fetch0", 32'h0);
        fetch("fetch4", 32'h4);
        fetch("fetch8", 32'h8);
        step("drain_rsp", 1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b1);

        // Rewrite, illegal loads, sticky error, clear on re-entry.
        step("enter_load2", 1'b1, 1'b0, '0, '0, 1'b0, '0, 1'b1);
        load("rewrite4", 32'h4, 32'h0);
        load("load_misal", 32'h6, 32'hDEAD_BEEF);
        load("load_range", 32'(DEPTH * 4), 32'hDEAD_BEEF);
        step("exit_load2", 1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b1);
        step("err_sticky", 1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b1);
        step("reenter_load", 1'b1, 1'b0, '0, '0, 1'b0, '0, 1'b1);
        step("exit_load3", 1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b1);

        // Fault codes and no aliasing of high addresses.
        fetch("fetch_misal", 32'h2);
        fetch("fetch_range", 32'(DEPTH * 4));
        fetch("fetch_alias", 32'hFFFF_FFFC);
        fetch("fetch4_new", 32'h4);
        fetch("fetch6", 32'h6);
        fetch("fetch_unwr", 32'h7C);

        // Backpressure, then DRAIN and the release into LOAD.
        fetch("bp_first", 32'h0);
        for (int i = 0; i < 3; i++) step("bp_hold", 1'b0, 1'b0, '0, '0, 1'b1, 32'h8, 1'b0);
        step("drain_enter", 1'b1, 1'b0, '0, '0, 1'b1, 32'h8, 1'b0);
        step("drain_hold", 1'b1, 1'b0, '0, '0, 1'b0, '0, 1'b0);
        step("drain_release", 1'b1, 1'b0, '0, '0, 1'b0, '0, 1'b1);
        step("load_after_drain", 1'b1, 1'b0, '0, '0, 1'b0, '0, 1'b1);
        step("exit_load4", 1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b1);

        // A request accepted as load_en rises still completes.
        step("req_on_load_en", 1'b1, 1'b0, '0, '0, 1'b1, 32'h8, 1'b1);
        step("req_completes", 1'b1, 1'b0, '0, '0, 1'b0, '0, 1'b0);
        step("exit_load5", 1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b1);

        // Randomized mix of loads, fetches and backpressure.
        le_r = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 11) == 0) le_r = ~le_r;
            step("rand", le_r, 1'($urandom_range(0, 1)), rand_addr(), $urandom(),
                 1'($urandom_range(0, 3) != 0), rand_addr(), 1'($urandom_range(0, 3) != 0));
        end
        step("rand_exit", 1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b1);

        // Asynchronous reset while a response is held.
        step("pre_rst_load_en", 1'b1, 1'b0, '0, '0, 1'b0, '0, 1'b1);
        load("pre_rst_load", 32'h0, 32'h1234_5678);
        step("pre_rst_exit", 1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b1);
        step("pre_rst_fetch", 1'b0, 1'b0, '0, '0, 1'b1, 32'h0, 1'b0);
        check("pre_rst.rsp_valid", 64'(rsp_valid), 64'(1));
        #2;
        reset_n   = 1'b0;
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        #1;
        model_reset();
        check_regs("async_rst");
        @(negedge clk);
        reset_n = 1'b1;
        fetch("post_rst_fetch", 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "time limit reached");
    end

endmodule
